mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised memory access unit between the multicycle CPU datapath and the single shared instruction/data memory port.
- Takes one load, store or fetch request at a time with a size code and a sign flag.
- Drives a word-aligned memory bus with byte enables and a req/ack handshake, so the memory may insert any number of wait states.
- Returns extended load data, a one-cycle completion pulse, and a CP0-compatible error cause.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, bus data width; legal values are 32 and 64.
- TIMEOUT_CYC, 16, cycles to wait for mem_ack before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load/fetch.
- cpu_size  in  2  access size: 00 word, 01 half, 10 byte, 11 dword. Dword applies only when DATA_W=64; otherwise it is treated as word.
- cpu_sign  in  1  1 = sign-extend loads, 0 = zero-extend.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data, right-justified.
- cpu_rdata  out  DATA_W  extended load data; holds until the next accepted request.
- cpu_busy  out  1  high from acceptance until cpu_done or cpu_err.
- cpu_done  out  1  one-cycle pulse on successful completion.
- cpu_err  out  1  one-cycle pulse on error.
- err_cause  out  5  cause code, valid with cpu_err and held afterwards.
- mem_addr  out  ADDR_W  cpu_addr with its low log2(DATA_W/8) bits cleared.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  bus write.
- mem_be  out  DATA_W/8  byte-lane enables.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction drops mem_req immediately and abandons the access; no done or err pulse is issued.
- States:
  - IDLE: cpu_req=1 latches addr/we/size/sign/wdata, sets cpu_busy, and goes to REQ.
  - REQ: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are registered and stable. On mem_ack, goes to DONE. On counter reaching TIMEOUT_CYC, goes to ERR.
  - DONE: cpu_done=1, cpu_rdata updated, cpu_busy=0, then back to IDLE.
  - ERR: cpu_err=1, err_cause=7 (DBE), cpu_busy=0, then back to IDLE.
- Latency with zero wait states: cpu_req sampled at cycle 0, mem_req at cycle 1, mem_ack at cycle 1, cpu_done at cycle 2. Each wait state adds one cycle.
- Lanes are little-endian. Lane offset is addr[log2(DATA_W/8)-1:0].
  - Stores replicate cpu_wdata into the selected lane(s) and set mem_be only for those lanes.
  - Loads extract the selected lane(s), then sign- or zero-extend to DATA_W.
- Timeout counter clears on entry to REQ and increments each REQ cycle without mem_ack. mem_ack in the same cycle the counter hits TIMEOUT_CYC counts as success.
- Ignored events:
  - cpu_req while busy, DONE or ERR.
  - mem_ack outside REQ.
  - A new cpu_req in the DONE cycle; it must be re-presented in IDLE.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - In IDLE, a request whose address is not a multiple of the access size goes directly to ERR without asserting mem_req.
  - err_cause = 4 (AdEL) for loads, 5 (AdES) for stores.
  - cpu_err occurs 1 cycle after cpu_req.
- Undefined: the low address bits below the access size are silently forced to zero and the access proceeds normally.

Decomposition:
- Package mem_pkg holds:
  - size codes SZ_WORD, SZ_HALF, SZ_BYTE, SZ_DWORD;
  - cause codes CAUSE_ADEL=4, CAUSE_ADES=5, CAUSE_DBE=7;
  - the state enum IDLE/REQ/DONE/ERR.
- One combinational sub-module, mem_lane_align, handles byte-enable generation, store lane insertion and load extraction/extension. It is parametrised by DATA_W.

Test Plan:
- DATA_W=32, load byte, addr 0x1003, sign=1, mem_rdata 0x80FF_0000 with 0 waits -> mem_be=4'b1000, cpu_done at cycle 2, cpu_rdata=0xFFFF_FF80.
- Store half, addr 0x2002, wdata 0x0000_ABCD, 3 wait states -> mem_wdata=0xABCD_ABCD, mem_be=4'b1100, mem_req held 4 cycles, cpu_done at cycle 5.
- TIMEOUT_CYC=4, mem_ack never asserted -> cpu_err pulse with err_cause=7, mem_req dropped, cpu_busy=0. A following request completes normally.
- With MEM_MISALIGN_TRAP_EN, load word at addr 0x0002 -> no mem_req, cpu_err at cycle 1, err_cause=4. Without the macro, mem_addr=0x0000 and the load completes.
- DATA_W=64, dword load at addr 0x8, zero-extend -> mem_be=8'hFF, cpu_rdata equals mem_rdata.
- Assert rst in the second wait cycle of a load -> mem_req=0 immediately, no cpu_done. A new request after reset completes in 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, cause codes, FSM states and lane helpers for mem_access_unit
package mem_pkg;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_BYTE  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_ADES = 5'd5;
    localparam logic [4:0] CAUSE_DBE  = 5'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // A dword request on a 32-bit bus behaves exactly like a word request.
    function automatic logic [1:0] norm_size(input logic [1:0] size, input int data_w);
        return (size == SZ_DWORD && data_w < 64) ? SZ_WORD : size;
    endfunction

    // Address bits that must be zero for an access of this (normalised) size.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd0;
            SZ_HALF: return 3'd1;
            SZ_WORD: return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable generation, store lane replication and load extraction/extension
//
// Ports: size/sign/offset describe the access; wdata is right-justified store data, rdata is the
// raw bus word. be, wdata_lane and rdata_ext are purely combinational results.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                   size,
    input  logic                         sign,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W-1:0]            rdata,
    output logic [DATA_W/8-1:0]          be,
    output logic [DATA_W-1:0]            wdata_lane,
    output logic [DATA_W-1:0]            rdata_ext
);

    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    logic [1:0]        eff;
    logic [OW-1:0]     lane;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              msb;

    always_comb begin
        eff        = norm_size(size, DATA_W);
        // Low offset bits below the access size are dropped, so unaligned
        // requests collapse onto the naturally aligned lane.
        lane       = offset & ~OW'(size_mask(eff));
        shifted    = rdata >> {lane, 3'b000};
        be         = '0;
        wdata_lane = '0;
        keep       = '1;
        msb        = 1'b0;
        case (eff)
            SZ_BYTE: begin
                be         = NB'(1) << lane;
                wdata_lane = {NB{wdata[7:0]}};
                keep       = DATA_W'(8'hFF);
                msb        = shifted[7];
            end
            SZ_HALF: begin
                be         = NB'(3) << lane;
                wdata_lane = {(NB/2){wdata[15:0]}};
                keep       = DATA_W'(16'hFFFF);
                msb        = shifted[15];
            end
            SZ_WORD: begin
                be         = NB'(15) << lane;
                wdata_lane = {(NB/4){wdata[31:0]}};
                keep       = DATA_W'(32'hFFFF_FFFF);
                msb        = shifted[31];
            end
            default: begin
                be         = '1;
                wdata_lane = wdata;
                keep       = '1;
                msb        = shifted[DATA_W-1];
            end
        endcase
        // Bits above the access size take the sign bit or zero.
        rdata_ext = (shifted & keep) | ({DATA_W{sign & msb}} & ~keep);
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding CPU load/store/fetch unit driving a req/ack memory bus
//
// Ports: cpu_* is the datapath side (request in, busy/done/err/rdata out), mem_* is the
// word-aligned bus side with byte enables. err_cause carries the CP0 cause code.
// Build option: MEM_MISALIGN_TRAP_EN traps size-misaligned requests (AdEL/AdES) instead of
// silently aligning them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_sign,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic [4:0]            err_cause,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    localparam int NB    = DATA_W / 8;
    localparam int OW    = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

    state_t            state;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [OW-1:0]     off_q;
    logic [CNT_W-1:0]  cnt;

    // The aligner sees the live request while idle (to build bus lanes at
    // acceptance) and the latched request afterwards (to extract load data).
    logic [1:0]        a_size;
    logic              a_sign;
    logic [OW-1:0]     a_off;
    logic [NB-1:0]     a_be;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              timeout_hit;

    assign a_size      = (state == IDLE) ? cpu_size : size_q;
    assign a_sign      = (state == IDLE) ? cpu_sign : sign_q;
    assign a_off       = (state == IDLE) ? cpu_addr[OW-1:0] : off_q;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC));

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(cpu_addr[OW-1:0] & OW'(size_mask(norm_size(cpu_size, DATA_W))));
`endif

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size       (a_size),
        .sign       (a_sign),
        .offset     (a_off),
        .wdata      (cpu_wdata),
        .rdata      (mem_rdata),
        .be         (a_be),
        .wdata_lane (a_wdata),
        .rdata_ext  (a_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            size_q    <= '0;
            sign_q    <= 1'b0;
            off_q     <= '0;
            cnt       <= '0;
            cpu_rdata <= '0;
            cpu_busy  <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            err_cause <= '0;
            mem_addr  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        size_q <= cpu_size;
                        sign_q <= cpu_sign;
                        off_q  <= cpu_addr[OW-1:0];
`ifdef MEM_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state     <= ERR;
                            cpu_err   <= 1'b1;
                            err_cause <= cpu_we ? CAUSE_ADES : CAUSE_ADEL;
                        end else begin
`else
                        begin
`endif
                            state     <= REQ;
                            cpu_busy  <= 1'b1;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_addr  <= {cpu_addr[ADDR_W-1:OW], {OW{1'b0}}};
                            mem_we    <= cpu_we;
                            mem_be    <= a_be;
                            mem_wdata <= a_wdata;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the timeout cycle still wins.
                    if (mem_ack) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        cpu_busy  <= 1'b0;
                        cpu_done  <= 1'b1;
                        cpu_rdata <= a_rdata;
                    end else if (timeout_hit) begin
                        state     <= ERR;
                        mem_req   <= 1'b0;
                        cpu_busy  <= 1'b0;
                        cpu_err   <= 1'b1;
                        err_cause <= CAUSE_DBE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit (32-bit and 64-bit builds)
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // 32-bit instance, short timeout
    logic        cpu_req = 0, cpu_we = 0, cpu_sign = 0, mem_ack = 0;
    logic [1:0]  cpu_size = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, mem_rdata = 0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        cpu_busy, cpu_done, cpu_err, mem_req, mem_we;
    logic [4:0]  err_cause;
    logic [3:0]  mem_be;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_sign(cpu_sign), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .err_cause(err_cause),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // 64-bit instance
    logic        w_req = 0, w_we = 0, w_sign = 0, w_ack = 0;
    logic [1:0]  w_size = 0;
    logic [31:0] w_addr = 0, w_maddr;
    logic [63:0] w_wdata = 0, w_mrdata = 0, w_rdata, w_mwdata;
    logic        w_busy, w_done, w_err, w_mreq, w_mwe;
    logic [4:0]  w_cause;
    logic [7:0]  w_be;

    mem_access_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(16)) dut_w (
        .clk(clk), .rst(rst), .cpu_req(w_req), .cpu_we(w_we), .cpu_size(w_size),
        .cpu_sign(w_sign), .cpu_addr(w_addr), .cpu_wdata(w_wdata), .cpu_rdata(w_rdata),
        .cpu_busy(w_busy), .cpu_done(w_done), .cpu_err(w_err), .err_cause(w_cause),
        .mem_addr(w_maddr), .mem_req(w_mreq), .mem_we(w_mwe), .mem_be(w_be),
        .mem_wdata(w_mwdata), .mem_rdata(w_mrdata), .mem_ack(w_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({cpu_rdata, cpu_busy, cpu_done, cpu_err, err_cause, mem_addr, mem_req, mem_we, mem_be, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset32: outputs not all zero, rdata=%h busy=%b req=%b be=%b", cpu_rdata, cpu_busy, mem_req, mem_be);
        end
        n_cmp++;
        if ({w_rdata, w_busy, w_done, w_err, w_cause, w_maddr, w_mreq, w_mwe, w_be, w_mwdata} !== '0) begin
            n_fail++;
            $display("FAIL reset64: outputs not all zero, rdata=%h busy=%b req=%b be=%b", w_rdata, w_busy, w_mreq, w_be);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_byte_signed();
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b10; cpu_sign = 1; cpu_addr = 32'h1003;
        step();                                   // cycle 1
        cpu_req = 0;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1000 || mem_addr !== 32'h1000 || cpu_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ldb_bus: req=%b be=%b addr=%h busy=%b, want 1 1000 00001000 1", mem_req, mem_be, mem_addr, cpu_busy);
        end
        mem_ack = 1; mem_rdata = 32'h80FF_0000;
        step();                                   // cycle 2
        mem_ack = 0;
        n_cmp++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'hFFFF_FF80 || cpu_busy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ldb_done: done=%b rdata=%h busy=%b req=%b, want 1 ffffff80 0 0", cpu_done, cpu_rdata, cpu_busy, mem_req);
        end
        step();                                   // cycle 3
        n_cmp++;
        if (cpu_done !== 1'b0 || cpu_rdata !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL ldb_pulse: done=%b rdata=%h, want 0 ffffff80", cpu_done, cpu_rdata);
        end
    endtask

    task automatic test_store_half_waits();
        int req_cycles;
        cpu_req = 1; cpu_we = 1; cpu_size = 2'b01; cpu_sign = 0; cpu_addr = 32'h2002; cpu_wdata = 32'h0000_ABCD;
        step();                                   // cycle 1
        cpu_req = 0;
        n_cmp++;
        if (mem_wdata !== 32'hABCD_ABCD || mem_be !== 4'b1100 || mem_we !== 1'b1 || mem_addr !== 32'h2000) begin
            n_fail++;
            $display("FAIL sth_bus: wdata=%h be=%b we=%b addr=%h, want abcdabcd 1100 1 00002000", mem_wdata, mem_be, mem_we, mem_addr);
        end
        req_cycles = 0;
        for (int c = 1; c <= 4; c++) begin
            if (mem_req === 1'b1) req_cycles++;
            mem_ack = (c == 4);
            step();
        end
        mem_ack = 0;                              // now in cycle 5
        n_cmp++;
        if (req_cycles != 4) begin
            n_fail++;
            $display("FAIL sth_req_len: mem_req held %0d cycles, want 4", req_cycles);
        end
        n_cmp++;
        if (cpu_done !== 1'b1 || mem_req !== 1'b0 || cpu_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sth_done: done=%b req=%b err=%b at cycle 5, want 1 0 0", cpu_done, mem_req, cpu_err);
        end
        step();
    endtask

    task automatic test_timeout();
        int err_cyc;
        bit saw_done;
        err_cyc = -1;
        saw_done = 0;
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b00; cpu_sign = 0; cpu_addr = 32'h3000;
        step();
        cpu_req = 0;
        for (int c = 1; c <= 20 && err_cyc < 0; c++) begin
            if (cpu_done === 1'b1) saw_done = 1;
            if (cpu_err === 1'b1) begin
                err_cyc = c;
                n_cmp++;
                if (err_cause !== 5'd7 || mem_req !== 1'b0 || cpu_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL to_state: cause=%0d req=%b busy=%b, want 7 0 0", err_cause, mem_req, cpu_busy);
                end
            end else begin
                step();
            end
        end
        n_cmp++;
        if (err_cyc != 6 || saw_done) begin
            n_fail++;
            $display("FAIL to_timing: cpu_err at cycle %0d (done seen=%0d), want 6 (0)", err_cyc, saw_done);
        end
        step();
        n_cmp++;
        if (cpu_err !== 1'b0 || err_cause !== 5'd7) begin
            n_fail++;
            $display("FAIL to_hold: err=%b cause=%0d, want 0 7", cpu_err, err_cause);
        end
        // following request completes normally
        cpu_req = 1; cpu_addr = 32'h3004;
        step();
        cpu_req = 0;
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 0;
        n_cmp++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL to_recover: done=%b rdata=%h, want 1 12345678", cpu_done, cpu_rdata);
        end
        step();
    endtask

    task automatic test_misaligned();
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b00; cpu_sign = 0; cpu_addr = 32'h0000_0002;
        step();                                   // cycle 1
        cpu_req = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        n_cmp++;
        if (cpu_err !== 1'b1 || err_cause !== 5'd4 || mem_req !== 1'b0 || cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_trap: err=%b cause=%0d req=%b busy=%b, want 1 4 0 0", cpu_err, err_cause, mem_req, cpu_busy);
        end
        step();
        step();
        cpu_req = 1; cpu_we = 1; cpu_size = 2'b01; cpu_addr = 32'h0000_0001;
        step();
        cpu_req = 0;
        n_cmp++;
        if (cpu_err !== 1'b1 || err_cause !== 5'd5 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_trap_st: err=%b cause=%0d req=%b, want 1 5 0", cpu_err, err_cause, mem_req);
        end
        step();
`else
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_be !== 4'b1111) begin
            n_fail++;
            $display("FAIL mis_align: req=%b addr=%h be=%b, want 1 00000000 1111", mem_req, mem_addr, mem_be);
        end
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 0;
        n_cmp++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'hCAFE_F00D || cpu_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_load: done=%b rdata=%h err=%b, want 1 cafef00d 0", cpu_done, cpu_rdata, cpu_err);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        // cpu_req held high: ignored in DONE, re-accepted in IDLE
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b10; cpu_sign = 0; cpu_addr = 32'h0000_0005;
        step();                                   // cycle 1
        mem_ack = 1; mem_rdata = 32'h0000_9A00;
        step();                                   // cycle 2 (DONE)
        mem_ack = 1;                              // ack outside REQ: ignored
        n_cmp++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0000_009A || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b rdata=%h req=%b, want 1 0000009a 0", cpu_done, cpu_rdata, mem_req);
        end
        step();                                   // cycle 3 (IDLE)
        mem_ack = 0;
        n_cmp++;
        if (mem_req !== 1'b0 || cpu_done !== 1'b0 || cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: req=%b done=%b busy=%b, want 0 0 0", mem_req, cpu_done, cpu_busy);
        end
        step();                                   // cycle 4
        cpu_req = 0;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_be !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_second: req=%b be=%b, want 1 0010", mem_req, mem_be);
        end
        mem_ack = 1; mem_rdata = 32'h0000_7F00;
        step();
        mem_ack = 0;
        n_cmp++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0000_007F) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b rdata=%h, want 1 0000007f", cpu_done, cpu_rdata);
        end
        step();
    endtask

    task automatic test_dword64();
        w_req = 1; w_we = 0; w_size = 2'b11; w_sign = 0; w_addr = 32'h8;
        step();
        w_req = 0;
        n_cmp++;
        if (w_mreq !== 1'b1 || w_be !== 8'hFF || w_maddr !== 32'h8) begin
            n_fail++;
            $display("FAIL d64_bus: req=%b be=%h addr=%h, want 1 ff 00000008", w_mreq, w_be, w_maddr);
        end
        w_ack = 1; w_mrdata = 64'hFEDC_BA98_7654_3210;
        step();
        w_ack = 0;
        n_cmp++;
        if (w_done !== 1'b1 || w_rdata !== 64'hFEDC_BA98_7654_3210) begin
            n_fail++;
            $display("FAIL d64_load: done=%b rdata=%h, want 1 fedcba9876543210", w_done, w_rdata);
        end
        step();
        w_req = 1; w_size = 2'b01; w_sign = 1; w_addr = 32'h0000_000E;
        step();
        w_req = 0;
        n_cmp++;
        if (w_be !== 8'hC0 || w_maddr !== 32'h8) begin
            n_fail++;
            $display("FAIL h64_bus: be=%h addr=%h, want c0 00000008", w_be, w_maddr);
        end
        w_ack = 1; w_mrdata = 64'h8001_0000_0000_0000;
        step();
        w_ack = 0;
        n_cmp++;
        if (w_done !== 1'b1 || w_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin
            n_fail++;
            $display("FAIL h64_load: done=%b rdata=%h, want 1 ffffffffffff8001", w_done, w_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 0;
        cpu_req = 1; cpu_we = 0; cpu_size = 2'b00; cpu_sign = 0; cpu_addr = 32'h40;
        step();                                   // cycle 1: first wait
        cpu_req = 0;
        step();                                   // cycle 2: second wait
        #3;
        rst = 1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: req=%b busy=%b after async reset, want 0 0", mem_req, cpu_busy);
        end
        step();
        rst = 0;
        mem_ack = 1;                              // stray ack in IDLE
        for (int c = 0; c < 3; c++) begin
            if (cpu_done === 1'b1 || cpu_err === 1'b1) saw_done = 1;
            step();
            mem_ack = 0;
        end
        n_cmp++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL rst_nodone: done/err pulse seen after reset, want none");
        end
        cpu_req = 1; cpu_addr = 32'h44;
        step();
        cpu_req = 0;
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 0;
        n_cmp++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL rst_after: done=%b rdata=%h, want 1 0badf00d", cpu_done, cpu_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_load_byte_signed();
        test_store_half_waits();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_dword64();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
